// File: rtl/depth_pkg.sv
// Shared types and constants for the depth-test / framebuffer-write stage.
package depth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_CLEAR
    } depth_state_t;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;
    localparam int DEF_Z_W   = 10;

    localparam logic [DEF_Z_W-1:0] MAX_DEPTH = '1;

    // y*640 + x without a multiplier: 640 = 512 + 128.
    function automatic logic [18:0] pixel_addr(input logic [9:0] x, input logic [9:0] y);
        logic [18:0] xe;
        logic [18:0] ye;
        xe = {9'd0, x};
        ye = {9'd0, y};
        return (ye << 9) + (ye << 7) + xe;
    endfunction

endpackage

// File: rtl/depth_test_stage_clear_sweeper.sv
// Address counter for the full-screen clear: start loads address 0, busy holds
// for DEPTH cycles, done flags the final address.
module clear_sweeper
    import depth_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DEPTH  = DEF_H_RES * DEF_V_RES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    assign done = busy && (addr == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            addr <= '0;
        end else if (start) begin
            busy <= 1'b1;
            addr <= '0;
        end else if (done) begin
            busy <= 1'b0;
            addr <= '0;
        end else if (busy) begin
            addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/depth_test_stage.sv
// Depth test and framebuffer write: read stored z, write z/colour when nearer,
// plus full-screen clear. Optional DEPTH_STATS_EN adds pass/fail counters.
module depth_test_stage
    import depth_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int Z_W    = DEF_Z_W,
    parameter int ADDR_W = 19
) (
    input  logic              clk_100MHz,
    input  logic              reset_al,
    input  logic              frag_valid,
    output logic              frag_ready,
    input  logic [9:0]        frag_x,
    input  logic [9:0]        frag_y,
    input  logic [Z_W-1:0]    frag_z,
    input  logic [7:0]        frag_rgb,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] zb_addr,
    output logic              zb_rd_en,
    input  logic [Z_W-1:0]    zb_rd_data,
    output logic              zb_wr_en,
    output logic [Z_W-1:0]    zb_wr_data,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_wr_en,
    output logic [7:0]        fb_wr_data
`ifdef DEPTH_STATS_EN
    ,
    output logic [31:0]       pass_count,
    output logic [31:0]       fail_count
`endif
);

    localparam logic [Z_W-1:0] CLEAR_Z = '1;

    depth_state_t      state_q, state_d;
    logic              frag_ready_q, frag_ready_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              accept;
    logic              sweep_start;
    logic              sweep_busy, sweep_done;
    logic [ADDR_W-1:0] sweep_addr;
    logic              in_range;
    logic [ADDR_W-1:0] pix_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [Z_W-1:0]    wr_z_q;
    logic [7:0]        wr_rgb_q;
    logic [Z_W-1:0]    frag_z_p0;
    logic [7:0]        frag_rgb_p0;

    assign in_range = (32'(frag_x) < H_RES) && (32'(frag_y) < V_RES);

    if (H_RES == DEF_H_RES && ADDR_W == 19) begin : g_shift_addr
        assign pix_addr = pixel_addr(frag_x, frag_y);
    end else begin : g_mul_addr
        assign pix_addr = ADDR_W'(32'(frag_y) * 32'(H_RES) + 32'(frag_x));
    end

    clear_sweeper #(
        .ADDR_W (ADDR_W),
        .DEPTH  (H_RES * V_RES)
    ) u_sweeper (
        .clk   (clk_100MHz),
        .rst_n (reset_al),
        .start (sweep_start),
        .busy  (sweep_busy),
        .done  (sweep_done),
        .addr  (sweep_addr)
    );

    always_comb begin
        state_d      = state_q;
        frag_ready_d = frag_ready_q;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        accept       = 1'b0;
        sweep_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                frag_ready_d = 1'b1;
                // Clear has priority over a fragment presented in the same cycle.
                if (clear_req) begin
                    sweep_start  = 1'b1;
                    frag_ready_d = 1'b0;
                    state_d      = ST_CLEAR;
                end else if (frag_valid && frag_ready_q) begin
                    accept = 1'b1;
                    if (in_range) begin
                        rd_en_d      = 1'b1;
                        frag_ready_d = 1'b0;
                        state_d      = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT: begin
                wr_en_d = (frag_z_p0 < zb_rd_data);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                frag_ready_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_CLEAR: begin
                frag_ready_d = 1'b0;
                if (sweep_done) begin
                    frag_ready_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // p0: fragment fields captured at the handshake
    always_ff @(posedge clk_100MHz) begin
        if (accept) begin
            frag_z_p0   <= frag_z;
            frag_rgb_p0 <= frag_rgb;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_al) begin
        if (!reset_al) begin
            state_q      <= ST_IDLE;
            frag_ready_q <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            wr_z_q       <= '0;
            wr_rgb_q     <= '0;
        end else begin
            state_q      <= state_d;
            frag_ready_q <= frag_ready_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            if (rd_en_d) begin
                addr_q <= pix_addr;
            end
            if (state_q == ST_WAIT) begin
                wr_z_q   <= frag_z_p0;
                wr_rgb_q <= frag_rgb_p0;
            end
        end
    end

    // The sweeper owns the memory ports while a clear is running.
    assign frag_ready = frag_ready_q;
    assign clear_busy = sweep_busy;
    assign zb_rd_en   = rd_en_q;
    assign zb_wr_en   = sweep_busy | wr_en_q;
    assign fb_wr_en   = sweep_busy | wr_en_q;
    assign zb_addr    = sweep_busy ? sweep_addr : addr_q;
    assign fb_addr    = sweep_busy ? sweep_addr : addr_q;
    assign zb_wr_data = sweep_busy ? CLEAR_Z : wr_z_q;
    assign fb_wr_data = sweep_busy ? 8'h00 : wr_rgb_q;

`ifdef DEPTH_STATS_EN
    always_ff @(posedge clk_100MHz or negedge reset_al) begin
        if (!reset_al) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (sweep_start) begin
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            if (state_q == ST_WRITE && wr_en_q) begin
                pass_count <= pass_count + 32'd1;
            end
            if ((state_q == ST_WRITE && !wr_en_q) || (accept && !in_range)) begin
                fail_count <= fail_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_depth_test_stage.sv
// Directed bench for depth_test_stage with a synchronous z/colour RAM model;
// built at 640x16 so a full clear sweep stays short.
module tb_depth_test_stage;
    import depth_pkg::*;

    localparam int H_RES  = 640;
    localparam int V_RES  = 16;
    localparam int Z_W    = 10;
    localparam int ADDR_W = 19;
    localparam int DEPTH  = H_RES * V_RES;

    logic              clk_100MHz = 1'b0;
    logic              reset_al   = 1'b1;
    logic              frag_valid = 1'b0;
    logic              clear_req  = 1'b0;
    logic [9:0]        frag_x     = '0;
    logic [9:0]        frag_y     = '0;
    logic [Z_W-1:0]    frag_z     = '0;
    logic [7:0]        frag_rgb   = '0;
    logic              frag_ready, clear_busy, zb_rd_en, zb_wr_en, fb_wr_en;
    logic [ADDR_W-1:0] zb_addr, fb_addr;
    logic [Z_W-1:0]    zb_rd_data, zb_wr_data;
    logic [7:0]        fb_wr_data;
`ifdef DEPTH_STATS_EN
    logic [31:0]       pass_count, fail_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [Z_W-1:0] zmem  [0:DEPTH-1];
    logic [7:0]     fbmem [0:DEPTH-1];

    always #5 clk_100MHz = ~clk_100MHz;

    depth_test_stage #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .Z_W    (Z_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset_al   (reset_al),
        .frag_valid (frag_valid),
        .frag_ready (frag_ready),
        .frag_x     (frag_x),
        .frag_y     (frag_y),
        .frag_z     (frag_z),
        .frag_rgb   (frag_rgb),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .zb_addr    (zb_addr),
        .zb_rd_en   (zb_rd_en),
        .zb_rd_data (zb_rd_data),
        .zb_wr_en   (zb_wr_en),
        .zb_wr_data (zb_wr_data),
        .fb_addr    (fb_addr),
        .fb_wr_en   (fb_wr_en),
        .fb_wr_data (fb_wr_data)
`ifdef DEPTH_STATS_EN
        ,
        .pass_count (pass_count),
        .fail_count (fail_count)
`endif
    );

    // External synchronous RAMs: read data one cycle after zb_rd_en.
    always @(posedge clk_100MHz) begin
        if (zb_wr_en && 32'(zb_addr) < DEPTH) zmem[zb_addr[13:0]] <= zb_wr_data;
        if (fb_wr_en && 32'(fb_addr) < DEPTH) fbmem[fb_addr[13:0]] <= fb_wr_data;
        if (zb_rd_en && 32'(zb_addr) < DEPTH) zb_rd_data <= zmem[zb_addr[13:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sweep_check(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk_100MHz);
            if (!(zb_wr_en && fb_wr_en && clear_busy && !frag_ready && !zb_rd_en &&
                  32'(zb_addr) == i && 32'(fb_addr) == i &&
                  zb_wr_data == MAX_DEPTH && fb_wr_data == 8'h00)) bad++;
        end
        check({tag, "_sweep_bad_cycles"}, 32'(bad), 32'd0);
        @(negedge clk_100MHz);
        check({tag, "_busy_after"}, 32'(clear_busy), 32'd0);
        check({tag, "_wr_after"}, 32'(zb_wr_en | fb_wr_en), 32'd0);
        check({tag, "_ready_after"}, 32'(frag_ready), 32'd1);
    endtask

    task automatic start_clear();
        @(negedge clk_100MHz);
        clear_req = 1'b1;
        @(posedge clk_100MHz);
        #1 clear_req = 1'b0;
    endtask

    task automatic send_frag(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] z, input logic [7:0] rgb);
        @(negedge clk_100MHz);
        check({tag, "_ready_before"}, 32'(frag_ready), 32'd1);
        frag_x     = x;
        frag_y     = y;
        frag_z     = z;
        frag_rgb   = rgb;
        frag_valid = 1'b1;
        @(posedge clk_100MHz);
        #1 frag_valid = 1'b0;
    endtask

    task automatic observe_frag(input string tag, input logic [18:0] a, input logic [9:0] z,
                                input logic [7:0] rgb, input logic pass);
        @(negedge clk_100MHz);
        check({tag, "_n1_rd_en"}, 32'(zb_rd_en), 32'd1);
        check({tag, "_n1_addr"}, 32'(zb_addr), 32'(a));
        check({tag, "_n1_ready"}, 32'(frag_ready), 32'd0);
        check({tag, "_n1_wr"}, 32'(zb_wr_en | fb_wr_en), 32'd0);
        @(negedge clk_100MHz);
        check({tag, "_n2_rd_wr"}, 32'(zb_rd_en | zb_wr_en | fb_wr_en), 32'd0);
        @(negedge clk_100MHz);
        check({tag, "_n3_zb_wr"}, 32'(zb_wr_en), 32'(pass));
        check({tag, "_n3_fb_wr"}, 32'(fb_wr_en), 32'(pass));
        if (pass) begin
            check({tag, "_n3_zdata"}, 32'(zb_wr_data), 32'(z));
            check({tag, "_n3_rgb"}, 32'(fb_wr_data), 32'(rgb));
            check({tag, "_n3_fb_addr"}, 32'(fb_addr), 32'(a));
        end
        @(negedge clk_100MHz);
        check({tag, "_n4_ready"}, 32'(frag_ready), 32'd1);
        check({tag, "_n4_wr"}, 32'(zb_wr_en | fb_wr_en), 32'd0);
    endtask

    task automatic send_oor(input string tag, input logic [9:0] x, input logic [9:0] y);
        send_frag(tag, x, y, 10'd1, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_100MHz);
            check({tag, "_ready"}, 32'(frag_ready), 32'd1);
            check({tag, "_no_access"}, 32'(zb_rd_en | zb_wr_en | fb_wr_en), 32'd0);
        end
    endtask

    initial begin
        logic found;

        #2 reset_al = 1'b0;
        repeat (3) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        check("rst_ready", 32'(frag_ready), 32'd0);
        check("rst_busy", 32'(clear_busy), 32'd0);
        check("rst_strobes", 32'({zb_rd_en, zb_wr_en, fb_wr_en}), 32'd0);
        check("rst_zb_addr", 32'(zb_addr), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_zb_data", 32'(zb_wr_data), 32'd0);
        check("rst_fb_data", 32'(fb_wr_data), 32'd0);
        @(posedge clk_100MHz);
        #1 reset_al = 1'b1;
        @(negedge clk_100MHz);
        check("release_ready_low", 32'(frag_ready), 32'd0);
        @(negedge clk_100MHz);
        check("release_ready_high", 32'(frag_ready), 32'd1);

        start_clear();
        sweep_check("clr1");

        send_frag("near", 10'd5, 10'd2, 10'd100, 8'hE0);
        observe_frag("near", 19'd1285, 10'd100, 8'hE0, 1'b1);
        send_frag("equal", 10'd5, 10'd2, 10'd100, 8'h03);
        observe_frag("equal", 19'd1285, 10'd100, 8'h03, 1'b0);
        send_frag("nearer", 10'd5, 10'd2, 10'd99, 8'h1C);
        observe_frag("nearer", 19'd1285, 10'd99, 8'h1C, 1'b1);
        check("mem_z_1285", 32'(zmem[1285]), 32'd99);
        check("mem_rgb_1285", 32'(fbmem[1285]), 32'h1C);

        send_oor("oor_x", 10'd640, 10'd0);
`ifdef DEPTH_STATS_EN
        check("stats_pass", pass_count, 32'd2);
        check("stats_fail", fail_count, 32'd2);
`endif
        send_oor("oor_y", 10'd0, 10'd16);

        send_frag("corner", 10'd639, 10'd15, 10'd0, 8'hFF);
        observe_frag("corner", 19'd10239, 10'd0, 8'hFF, 1'b1);

        // Clear and fragment in the same cycle: clear first, fragment afterwards.
        @(negedge clk_100MHz);
        clear_req  = 1'b1;
        frag_valid = 1'b1;
        frag_x     = 10'd1;
        frag_y     = 10'd0;
        frag_z     = 10'd5;
        frag_rgb   = 8'h03;
        @(posedge clk_100MHz);
        #1 clear_req = 1'b0;
        sweep_check("clr2");
        @(posedge clk_100MHz);
        #1 frag_valid = 1'b0;
        observe_frag("held", 19'd1, 10'd5, 8'h03, 1'b1);
        check("mem_corner_cleared", 32'(zmem[10239]), 32'(MAX_DEPTH));

        send_frag("pre_abort", 10'd5, 10'd2, 10'd200, 8'h55);
        observe_frag("pre_abort", 19'd1285, 10'd200, 8'h55, 1'b1);

        // Reset in the middle of a sweep.
        start_clear();
        found = 1'b0;
        for (int i = 0; i < DEPTH + 4 && !found; i++) begin
            @(negedge clk_100MHz);
            if (clear_busy && 32'(zb_addr) == 1000) found = 1'b1;
        end
        check("sweep_reached_1000", 32'(found), 32'd1);
        reset_al = 1'b0;
        #1;
        check("abort_strobes", 32'({zb_rd_en, zb_wr_en, fb_wr_en}), 32'd0);
        check("abort_busy", 32'(clear_busy), 32'd0);
        check("abort_ready", 32'(frag_ready), 32'd0);
        check("abort_addr", 32'(zb_addr), 32'd0);
        repeat (2) @(posedge clk_100MHz);
        #1 reset_al = 1'b1;
        @(negedge clk_100MHz);
        check("abort_release_ready_low", 32'(frag_ready), 32'd0);
        @(negedge clk_100MHz);
        check("abort_release_ready_high", 32'(frag_ready), 32'd1);
        check("abort_release_idle", 32'({clear_busy, zb_wr_en, fb_wr_en}), 32'd0);

        send_frag("post_equal", 10'd5, 10'd2, 10'd200, 8'h11);
        observe_frag("post_equal", 19'd1285, 10'd200, 8'h11, 1'b0);
        send_frag("post_near", 10'd5, 10'd2, 10'd150, 8'h77);
        observe_frag("post_near", 19'd1285, 10'd150, 8'h77, 1'b1);
        check("mem_z_final", 32'(zmem[1285]), 32'd150);
        check("mem_rgb_final", 32'(fbmem[1285]), 32'h77);
        check("mem_held_recleared", 32'(zmem[1]), 32'(MAX_DEPTH));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
